decode_1: RTL and testbench

- First decode stage of the core pipeline; sits between instruction fetch and decode_2.
- Accepts fetched (PC, instruction) pairs over a valid/ready handshake and buffers them in a small FIFO so fetch can run ahead during stalls.
- Splits each instruction into opcode/rd/rs1/rs2/funct3/funct7.
- Generates all five sign-extended immediates (I/S/B/U/J); decode_2 selects among them.

---
 rtl/core_pkg.sv | 46 ++++
 rtl/decode_1_if.sv | 21 ++
 rtl/decode_1_fifo.sv | 52 +++++
 rtl/decode_1.sv | 103 ++++++++++
 tb/tb_decode_1.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared decode definitions: opcode map, fetch bundle and
// immediate extraction used by decode_1 and decode_2.
package core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

  function automatic logic is_rv32(input logic [31:0] w);
    return w[1:0] == 2'b11;
  endfunction

  function automatic logic [31:0] imm_i(input logic [31:0] w);
    return {{20{w[31]}}, w[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] w);
    return {{20{w[31]}}, w[31:25], w[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] w);
    return {w[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/decode_1_if.sv
// Fetch-to-decode_1 valid/ready handshake.
interface decode_1_if;
  logic        FETCH_VALID;
  logic        FETCH_READY;
  logic [31:0] FETCH_PC;
  logic [31:0] FETCH_INST;

  modport master (
    output FETCH_VALID,
    output FETCH_PC,
    output FETCH_INST,
    input  FETCH_READY
  );

  modport slave (
    input  FETCH_VALID,
    input  FETCH_PC,
    input  FETCH_INST,
    output FETCH_READY
  );
endinterface

// File: rtl/decode_1_fifo.sv
// Circular PC+instruction buffer letting fetch run ahead
// of a stalled decode_1 output register.
module decode_1_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  fetch_t      din,
  output fetch_t      dout,
  output logic [AW:0] count
);

  fetch_t          mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;

  assign dout = mem[rptr];

  always_ff @(posedge clk) begin
    if (push && !clear)
      mem[wptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      if (push && !pop)
        count <= count + (AW+1)'(1);
      else if (pop && !push)
        count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/decode_1.sv
// First decode stage: buffers fetched words, splits fields
// and produces all sign-extended immediates.
module decode_1
  import core_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  decode_1_if.slave   fetch,
  input  logic        STALL,
  input  logic        FLUSH,
  output logic        DECODE1_VALID,
  output logic [31:0] DECODE1_PC,
  output logic [6:0]  DECODE1_OPCODE,
  output logic [4:0]  DECODE1_RD,
  output logic [4:0]  DECODE1_RS1,
  output logic [4:0]  DECODE1_RS2,
  output logic [2:0]  DECODE1_FUNCT3,
  output logic [6:0]  DECODE1_FUNCT7,
  output logic [31:0] DECODE1_IMM_I,
  output logic [31:0] DECODE1_IMM_S,
  output logic [31:0] DECODE1_IMM_B,
  output logic [31:0] DECODE1_IMM_U,
  output logic [31:0] DECODE1_IMM_J
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] count;
  fetch_t      head;
  fetch_t      in_word;
  fetch_t      nxt;
  logic        accept;
  logic        has_data;
  logic        push;
  logic        pop;
  logic        load;

  assign fetch.FETCH_READY =
    !RST && (count < (AW+1)'(FIFO_DEPTH));

  assign accept   = fetch.FETCH_VALID && fetch.FETCH_READY;
  assign in_word  = '{pc: fetch.FETCH_PC,
                      inst: fetch.FETCH_INST};
  assign has_data = count != '0;

  // Empty buffer with a live input bypasses straight to output
  assign pop  = !FLUSH && !STALL && has_data;
  assign push = !FLUSH && accept && (STALL || has_data);
  assign load = !FLUSH && !STALL && (has_data || accept);
  assign nxt  = has_data ? head : in_word;

  decode_1_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (CLK),
    .rst  (RST),
    .push (push),
    .pop  (pop),
    .clear(FLUSH),
    .din  (in_word),
    .dout (head),
    .count(count)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DECODE1_VALID  <= 1'b0;
      DECODE1_PC     <= '0;
      DECODE1_OPCODE <= '0;
      DECODE1_RD     <= '0;
      DECODE1_RS1    <= '0;
      DECODE1_RS2    <= '0;
      DECODE1_FUNCT3 <= '0;
      DECODE1_FUNCT7 <= '0;
      DECODE1_IMM_I  <= '0;
      DECODE1_IMM_S  <= '0;
      DECODE1_IMM_B  <= '0;
      DECODE1_IMM_U  <= '0;
      DECODE1_IMM_J  <= '0;
    end else if (FLUSH) begin
      DECODE1_VALID <= 1'b0;
    end else if (load) begin
      DECODE1_VALID  <= is_rv32(nxt.inst);
      DECODE1_PC     <= nxt.pc;
      DECODE1_OPCODE <= nxt.inst[6:0];
      DECODE1_RD     <= nxt.inst[11:7];
      DECODE1_RS1    <= nxt.inst[19:15];
      DECODE1_RS2    <= nxt.inst[24:20];
      DECODE1_FUNCT3 <= nxt.inst[14:12];
      DECODE1_FUNCT7 <= nxt.inst[31:25];
      DECODE1_IMM_I  <= imm_i(nxt.inst);
      DECODE1_IMM_S  <= imm_s(nxt.inst);
      DECODE1_IMM_B  <= imm_b(nxt.inst);
      DECODE1_IMM_U  <= imm_u(nxt.inst);
      DECODE1_IMM_J  <= imm_j(nxt.inst);
    end else if (!STALL) begin
      DECODE1_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_1.sv
// Randomized and directed checks of decode_1 against a
// queue-based reference model.
module tb_decode_1;

  localparam int DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        STALL;
  logic        FLUSH;
  logic        dv;
  logic [31:0] dpc;
  logic [6:0]  op;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] ii;
  logic [31:0] is_;
  logic [31:0] ib;
  logic [31:0] iu;
  logic [31:0] ij;
  logic [224:0] got_all;

  decode_1_if fif();

  decode_1 #(.FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK),
    .RST(RST),
    .fetch(fif),
    .STALL(STALL),
    .FLUSH(FLUSH),
    .DECODE1_VALID(dv),
    .DECODE1_PC(dpc),
    .DECODE1_OPCODE(op),
    .DECODE1_RD(rd),
    .DECODE1_RS1(rs1),
    .DECODE1_RS2(rs2),
    .DECODE1_FUNCT3(f3),
    .DECODE1_FUNCT7(f7),
    .DECODE1_IMM_I(ii),
    .DECODE1_IMM_S(is_),
    .DECODE1_IMM_B(ib),
    .DECODE1_IMM_U(iu),
    .DECODE1_IMM_J(ij)
  );

  always #5 CLK = ~CLK;

  assign got_all = {dv, dpc, op, rd, rs1, rs2, f3, f7,
                    ii, is_, ib, iu, ij};

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] q[$];
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_inst;

  function automatic logic [31:0] e_i(input logic [31:0] w);
    int v;
    v = int'(w[30:20]) - (w[31] ? 2048 : 0);
    return 32'(v);
  endfunction

  function automatic logic [31:0] e_s(input logic [31:0] w);
    int v;
    v = int'(w[30:25]) * 32 + int'(w[11:7])
        - (w[31] ? 2048 : 0);
    return 32'(v);
  endfunction

  function automatic logic [31:0] e_b(input logic [31:0] w);
    int v;
    v = int'(w[11:8]) * 2 + int'(w[30:25]) * 32
        + int'(w[7]) * 2048 - (w[31] ? 4096 : 0);
    return 32'(v);
  endfunction

  function automatic logic [31:0] e_u(input logic [31:0] w);
    return w & 32'hFFFF_F000;
  endfunction

  function automatic logic [31:0] e_j(input logic [31:0] w);
    int v;
    v = int'(w[30:21]) * 2 + int'(w[20]) * 2048
        + int'(w[19:12]) * 4096 - (w[31] ? (1 << 20) : 0);
    return 32'(v);
  endfunction

  function automatic logic [224:0] exp_all();
    return {m_valid, m_pc, m_inst[6:0], m_inst[11:7],
            m_inst[19:15], m_inst[24:20], m_inst[14:12],
            m_inst[31:25], e_i(m_inst), e_s(m_inst),
            e_b(m_inst), e_u(m_inst), e_j(m_inst)};
  endfunction

  function automatic void model_reset();
    q.delete();
    m_valid = 1'b0;
    m_pc    = '0;
    m_inst  = '0;
  endfunction

  function automatic void model_load(input logic [63:0] e);
    m_pc    = e[63:32];
    m_inst  = e[31:0];
    m_valid = (e[1:0] == 2'b11);
  endfunction

  task automatic cycle(input logic v, input logic [31:0] pc,
                       input logic [31:0] inst,
                       input logic st, input logic fl);
    logic acc;
    fif.FETCH_VALID = v;
    fif.FETCH_PC    = pc;
    fif.FETCH_INST  = inst;
    STALL = st;
    FLUSH = fl;
    acc = v && !RST && (q.size() < DEPTH);
    @(posedge CLK);
    if (fl) begin
      q.delete();
      m_valid = 1'b0;
    end else if (!st) begin
      if (q.size() > 0) begin
        model_load(q.pop_front());
        if (acc) q.push_back({pc, inst});
      end else if (acc) begin
        model_load({pc, inst});
      end else begin
        m_valid = 1'b0;
      end
    end else if (acc) begin
      q.push_back({pc, inst});
    end
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1;
    vectors++;
    if (got_all !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", got_all);
    end
    vectors++;
    if (fif.FETCH_READY !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 0",
               fif.FETCH_READY);
    end
    RST = 1'b0;
    #1;
    vectors++;
    if (fif.FETCH_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b want 1",
               fif.FETCH_READY);
    end
  endtask

  task automatic test_single();
    cycle(1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0);
    vectors++;
    if ({dv, op, rd, rs1, f3, ii} !==
        {1'b1, 7'b0010011, 5'd1, 5'd0, 3'd0, 32'd5}) begin
      miscompares++;
      $display("FAIL single_addi: got %b %b %0d %0d %0d %h want 1 0010011 1 0 0 5",
               dv, op, rd, rs1, f3, ii);
    end
    vectors++;
    if (got_all !== exp_all()) begin
      miscompares++;
      $display("FAIL single_model: got %h want %h",
               got_all, exp_all());
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (dv !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drain: got %b want 0", dv);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 32'h4, 32'h0020_A423, 1'b0, 1'b0);
    vectors++;
    if ({dv, rs1, rs2, f3, is_, fif.FETCH_READY} !==
        {1'b1, 5'd1, 5'd2, 3'b010, 32'd8, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_store: got %b %0d %0d %b %h rdy %b want 1 1 2 010 8 rdy 1",
               dv, rs1, rs2, f3, is_, fif.FETCH_READY);
    end
    cycle(1'b1, 32'h8, 32'hFE00_0EE3, 1'b0, 1'b0);
    vectors++;
    if ({dv, dpc, ib, fif.FETCH_READY} !==
        {1'b1, 32'h8, 32'hFFFF_FFFC, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_branch: got %b %h %h rdy %b want 1 8 fffffffc rdy 1",
               dv, dpc, ib, fif.FETCH_READY);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    cycle(1'b1, 32'hC, 32'h1234_52B7, 1'b1, 1'b0);
    cycle(1'b1, 32'h10, 32'hFF9F_F06F, 1'b1, 1'b0);
    vectors++;
    if (fif.FETCH_READY !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_full_ready: got %b want 0",
               fif.FETCH_READY);
    end
    cycle(1'b1, 32'h14, 32'h0000_0013, 1'b1, 1'b0);
    cycle(1'b1, 32'h14, 32'h0000_0013, 1'b1, 1'b0);
    vectors++;
    if (dv !== m_valid || (m_valid && got_all !== exp_all())) begin
      miscompares++;
      $display("FAIL stall_hold: got %h want %h",
               got_all, exp_all());
    end
    cycle(1'b1, 32'h14, 32'h0000_0013, 1'b0, 1'b0);
    vectors++;
    if ({dv, iu, rd} !== {1'b1, 32'h1234_5000, 5'd5}) begin
      miscompares++;
      $display("FAIL stall_lui: got %b %h %0d want 1 12345000 5",
               dv, iu, rd);
    end
    cycle(1'b1, 32'h14, 32'h0000_0013, 1'b0, 1'b0);
    vectors++;
    if ({dv, ij} !== {1'b1, 32'hFFFF_FFF8}) begin
      miscompares++;
      $display("FAIL stall_jal: got %b %h want 1 fffffff8",
               dv, ij);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if ({dv, dpc, op} !== {1'b1, 32'h14, 7'b0010011}) begin
      miscompares++;
      $display("FAIL stall_addi: got %b %h %b want 1 14 0010011",
               dv, dpc, op);
    end
  endtask

  task automatic test_flush();
    cycle(1'b1, 32'h60, 32'h0010_0093, 1'b1, 1'b0);
    cycle(1'b1, 32'h64, 32'h0020_0113, 1'b1, 1'b0);
    cycle(1'b1, 32'h68, 32'h0030_0193, 1'b1, 1'b1);
    vectors++;
    if ({dv, fif.FETCH_READY} !== 2'b01) begin
      miscompares++;
      $display("FAIL flush_now: got v %b rdy %b want v 0 rdy 1",
               dv, fif.FETCH_READY);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (dv !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_empty: got %b pc %h want 0", dv, dpc);
    end
    cycle(1'b1, 32'h6C, 32'h0040_0213, 1'b0, 1'b0);
    vectors++;
    if ({dv, dpc} !== {1'b1, 32'h6C}) begin
      miscompares++;
      $display("FAIL flush_after: got %b %h want 1 6c", dv, dpc);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 32'h40, 32'h0030_0193, 1'b1, 1'b0);
    fif.FETCH_VALID = 1'b0;
    STALL = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    vectors++;
    if (got_all !== '0) begin
      miscompares++;
      $display("FAIL async_reset_out: got %h want 0", got_all);
    end
    vectors++;
    if (fif.FETCH_READY !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_ready: got %b want 0",
               fif.FETCH_READY);
    end
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    cycle(1'b1, 32'h44, 32'h0040_0213, 1'b0, 1'b0);
    vectors++;
    if ({dv, dpc} !== {1'b1, 32'h44} ||
        got_all !== exp_all()) begin
      miscompares++;
      $display("FAIL async_reset_latency: got %h want %h",
               got_all, exp_all());
    end
  endtask

  task automatic test_compressed();
    cycle(1'b1, 32'h80, 32'h0000_4501, 1'b0, 1'b0);
    vectors++;
    if (dv !== 1'b0) begin
      miscompares++;
      $display("FAIL compressed: got %b want 0", dv);
    end
    cycle(1'b1, 32'h82, 32'h0010_0113, 1'b0, 1'b0);
    vectors++;
    if ({dv, dpc, rd} !== {1'b1, 32'h82, 5'd2}) begin
      miscompares++;
      $display("FAIL after_compressed: got %b %h %0d want 1 82 2",
               dv, dpc, rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] inst;
    logic [31:0] pc;
    logic v;
    logic st;
    logic fl;
    pc = 32'h1000;
    for (int n = 0; n < 400; n++) begin
      inst = $urandom();
      if ($urandom_range(0, 7) != 0) inst[1:0] = 2'b11;
      v  = ($urandom_range(0, 9) < 7);
      st = ($urandom_range(0, 9) < 3);
      fl = ($urandom_range(0, 19) == 0);
      vectors++;
      if (fif.FETCH_READY !== (q.size() < DEPTH)) begin
        miscompares++;
        $display("FAIL rnd_ready[%0d]: got %b want %b", n,
                 fif.FETCH_READY, (q.size() < DEPTH));
      end
      cycle(v, pc, inst, st, fl);
      pc = pc + 4;
      vectors++;
      if (m_valid ? (got_all !== exp_all()) : (dv !== 1'b0)) begin
        miscompares++;
        $display("FAIL rnd_out[%0d]: got %h want %h", n,
                 got_all, exp_all());
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    STALL = 1'b0;
    FLUSH = 1'b0;
    fif.FETCH_VALID = 1'b0;
    fif.FETCH_PC = '0;
    fif.FETCH_INST = '0;
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_compressed();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
